fetch_sequencer: RTL and testbench

//  Control-side partner of the 16-bit program counter. Drives its inc/add/sub/offset controls.
//  - Fetches the instruction at pc from instruction memory over a req/ack handshake.
//  - Resolves jumps internally by pulsing the PC controls.
//  - Hands all other instructions to the execute stage over a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Control-side partner of the 16-bit program counter. Fetches the instruction
// at pc from instruction memory (req/ack). Jumps are resolved locally by
// pulsing the PC controls. All other instructions are handed to execute
// (valid/ready) and are followed by a PC increment.
//
// Per instruction: FETCH -> DECODE -> [ISSUE] -> STEP -> FETCH.
// HALT is terminal until reset.
//
// Opcode = ir[15:12], imm = {4'b0, ir[11:0]}:
//   F HALT, E JMPF (pc+imm), D JMPB (pc-imm), C BZF (z ? pc+imm : pc+1),
//   anything else is an ordinary instruction.
//
// Build option:
//   FETCH_TIMEOUT_EN  When defined, FETCH gives up after TIMEOUT request
//                     cycles without mem_ack. It then raises fetch_err
//                     (sticky) and halts. When undefined, FETCH waits
//                     forever and fetch_err is tied 0.
//
// Parameters:
//   TIMEOUT   fetch wait limit in cycles (1..255); only used with
//             FETCH_TIMEOUT_EN
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   pc            current PC value (the PC register lives outside this block)
//   mem_addr      instruction address, combinationally equal to pc
//   mem_req       fetch request, held until mem_ack
//   mem_ack       memory response; mem_data is valid in the same cycle
//   mem_data      instruction word
//   z_flag        zero flag from execute, sampled in DECODE for BZF
//   ir            latched instruction word
//   ir_valid      ir offered to execute
//   ir_ready      execute accepts ir
//   inc/add/sub   one-hot, single-cycle PC controls
//   offset        PC offset operand; 0 unless add/sub is pulsing
//   halted        HALT reached (sticky until reset)
//   fetch_err     fetch timeout (sticky until reset)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [15:0] mem_data,
   input  logic        z_flag,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic        inc,
   output logic        add,
   output logic        sub,
   output logic [15:0] offset,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_STEP,
      S_HALT
   } state_t;

   // One PC update: which control to pulse and its operand.
   typedef struct packed {
      logic        inc;
      logic        add;
      logic        sub;
      logic [15:0] offset;
   } pc_step_t;

   localparam logic [3:0] OP_BZF  = 4'hC;
   localparam logic [3:0] OP_JMPB = 4'hD;
   localparam logic [3:0] OP_JMPF = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t     state;
   logic [3:0] opcode;
   logic [15:0] imm;
   logic       is_halt;
   logic       is_jump;
   pc_step_t   jump_step;

   assign mem_addr = pc;
   assign opcode   = ir[15:12];
   assign imm      = {4'h0, ir[11:0]};

   // Decode of the latched word.
   // Only meaningful in DECODE, which is the cycle z_flag is sampled.
   // A BZF that is not taken is still handled as a jump: it goes straight
   // to STEP with an inc and is never offered to execute.
   always_comb begin
      jump_step = '0;
      is_halt   = 1'b0;
      is_jump   = 1'b0;
      case (opcode)
         OP_HALT: is_halt = 1'b1;
         OP_JMPF: begin
            is_jump          = 1'b1;
            jump_step.add    = 1'b1;
            jump_step.offset = imm;
         end
         OP_JMPB: begin
            is_jump          = 1'b1;
            jump_step.sub    = 1'b1;
            jump_step.offset = imm;
         end
         OP_BZF: begin
            is_jump = 1'b1;
            if (z_flag) begin
               jump_step.add    = 1'b1;
               jump_step.offset = imm;
            end else begin
               jump_step.inc    = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef FETCH_TIMEOUT_EN
   // Counts request cycles without an ack. Cleared whenever FETCH is entered.
   logic [7:0] wait_cnt;
   logic       timeout_hit;

   assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign fetch_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         mem_req  <= 1'b0;
         ir       <= '0;
         ir_valid <= 1'b0;
         inc      <= 1'b0;
         add      <= 1'b0;
         sub      <= 1'b0;
         offset   <= '0;
         halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         fetch_err <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         // PC controls are single-cycle pulses. They return to 0 unless
         // re-armed below.
         inc    <= 1'b0;
         add    <= 1'b0;
         sub    <= 1'b0;
         offset <= '0;

         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  // Only reachable in the first cycle after reset, because
                  // reset clears mem_req. Start requesting now; an ack that
                  // arrives without a request is ignored.
                  mem_req <= 1'b1;
               end else if (mem_ack) begin
                  ir      <= mem_data;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
`ifdef FETCH_TIMEOUT_EN
               else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  fetch_err <= 1'b1;
                  halted    <= 1'b1;
                  state     <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end

            S_DECODE: begin
               if (is_halt) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (is_jump) begin
                  inc    <= jump_step.inc;
                  add    <= jump_step.add;
                  sub    <= jump_step.sub;
                  offset <= jump_step.offset;
                  state  <= S_STEP;
               end else begin
                  ir_valid <= 1'b1;
                  state    <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               // ir is not written outside FETCH, so it stays stable
               // while offered.
               if (ir_ready) begin
                  ir_valid <= 1'b0;
                  inc      <= 1'b1;
                  state    <= S_STEP;
               end
            end

            S_STEP: begin
               // The pulse is visible during this cycle. The PC takes it at
               // the end of the cycle, so the next fetch addresses the new pc.
               mem_req <= 1'b1;
               state   <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end

            S_HALT: ;

            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_sequencer.
// The bench holds a behavioural PC register driven by the DUT controls.
// A per-instruction reference model tracks:
//   - the address the next fetch must use,
//   - whether the word must be offered to execute,
//   - which single PC control and offset must follow.
// Directed cases come first, then randomized segments.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        z_flag;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic        inc, add, sub;
   logic [15:0] offset;
   logic        halted;
   logic        fetch_err;

   fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .pc(pc), .mem_addr(mem_addr),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
      .z_flag(z_flag), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .inc(inc), .add(add), .sub(sub), .offset(offset),
      .halted(halted), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // External program counter, modulo 2^16.
   logic        pc_load;
   logic [15:0] pc_load_val;
   always @(posedge clk) begin
      if (pc_load)  pc <= pc_load_val;
      else if (inc) pc <= pc + 16'd1;
      else if (add) pc <= pc + offset;
      else if (sub) pc <= pc - offset;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [15:0] exp_pc;
   bit          pend_issue;
   logic [15:0] pend_word;
   bit          pend_ctrl;
   logic [2:0]  pend_ias;      // {inc, add, sub}
   logic [15:0] pend_off;
   bit          exp_halt;
   int          halt_age;
   int          exp_lat;
   int          last_ack_cyc;
   int          cyc = 0;
   int          idle;
   int          acks_done = 0;
   bit          timed_out = 0;
   int          iv_seen;
   int          pulses_seen;

   // Stimulus knobs
   int          ack_pct  = 100;
   int          rdy_pct  = 100;
   int          max_wait = 0;
   int          req_wait = 0;
   int          stall_left = 0;
   bit          lat_on = 0;
   logic [15:0] words[$];
   bit          z_q[$];

   function automatic logic [15:0] rand_word();
      int r;
      logic [15:0] w;
      r = $urandom_range(99);
      w = 16'($urandom);
      if (r < 15)      w[15:12] = 4'hE;
      else if (r < 30) w[15:12] = 4'hD;
      else if (r < 45) w[15:12] = 4'hC;
      else             w[15:12] = 4'($urandom_range(11));
      if ($urandom_range(9) == 0) w[11:0] = 12'h000;
      return w;
   endfunction

   // What the specification says one instruction must do.
   task automatic expect_instr(input logic [15:0] w, input bit z);
      logic [15:0] imm;
      imm = {4'h0, w[11:0]};
      case (w[15:12])
         4'hF: begin exp_halt = 1; halt_age = 0; end
         4'hE: begin pend_ctrl = 1; pend_ias = 3'b010; pend_off = imm; exp_pc = exp_pc + imm; exp_lat = 3; end
         4'hD: begin pend_ctrl = 1; pend_ias = 3'b001; pend_off = imm; exp_pc = exp_pc - imm; exp_lat = 3; end
         4'hC: begin
            pend_ctrl = 1; exp_lat = 3;
            if (z) begin pend_ias = 3'b010; pend_off = imm;   exp_pc = exp_pc + imm;   end
            else   begin pend_ias = 3'b100; pend_off = 16'd0; exp_pc = exp_pc + 16'd1; end
         end
         default: begin
            pend_issue = 1; pend_word = w;
            pend_ctrl = 1; pend_ias = 3'b100; pend_off = 16'd0;
            exp_pc = exp_pc + 16'd1; exp_lat = 4;
         end
      endcase
   endtask

   // One clock: observe outputs at negedge, check them, drive the next inputs.
   task automatic tick();
      @(negedge clk);
      cyc++;
      idle++;
      check("onehot", {31'd0, ($countones({inc, add, sub}) <= 1)}, 32'd1);
      if (!(inc | add | sub)) check("offset_idle", 32'(offset), 32'd0);

      if (inc | add | sub) begin
         idle = 0;
         pulses_seen++;
         if (!pend_ctrl || pend_issue) check("pulse_unexpected", 32'({inc, add, sub}), 32'd0);
         else begin
            check("pulse_kind", 32'({inc, add, sub}), 32'(pend_ias));
            check("pulse_offset", 32'(offset), 32'(pend_off));
            pend_ctrl = 0;
         end
      end

      if (ir_valid) begin
         if (!pend_issue) check("ir_valid_unexpected", 32'(ir_valid), 32'd0);
         else begin
            check("ir_word", 32'(ir), 32'(pend_word));
            iv_seen++;
         end
      end
      if (ir_valid && pend_issue && stall_left > 0) begin
         ir_ready = 1'b0;
         stall_left--;
      end else begin
         ir_ready = ($urandom_range(99) < rdy_pct);
      end
      if (ir_valid && ir_ready && pend_issue) begin
         pend_issue = 0;
         idle = 0;
      end

      if (exp_halt) begin
         halt_age++;
         idle = 0;
         if (halt_age > 2) begin
            check("halted", 32'(halted), 32'd1);
            check("no_req_after_halt", 32'(mem_req), 32'd0);
         end
         mem_ack  = 1'($urandom_range(1));
         mem_data = 16'($urandom);
      end else if (mem_req) begin
         mem_ack = ($urandom_range(99) < ack_pct) || (max_wait > 0 && req_wait >= max_wait);
         if (mem_ack) begin
            req_wait = 0;
            check("prev_instr_done", {30'd0, pend_issue, pend_ctrl}, 32'd0);
            check("mem_addr", 32'(mem_addr), 32'(exp_pc));
            check("halted_in_fetch", 32'(halted), 32'd0);
            if (lat_on && last_ack_cyc >= 0) check("latency", 32'(cyc - last_ack_cyc), 32'(exp_lat));
            last_ack_cyc = cyc;
            mem_data = (words.size() > 0) ? words.pop_front() : rand_word();
            z_flag   = (z_q.size() > 0) ? z_q.pop_front() : 1'($urandom_range(1));
            expect_instr(mem_data, z_flag);
            acks_done++;
            idle = 0;
         end else begin
            req_wait++;
            mem_data = 16'($urandom);
         end
      end else begin
         mem_ack  = 1'($urandom_range(1));
         mem_data = 16'($urandom);
      end

      if (idle > 60 && !timed_out) begin
         check("watchdog_idle", 32'(idle), 32'd0);
         timed_out = 1;
      end
   endtask

   task automatic do_reset(input logic [15:0] start_pc);
      reset = 1'b1; pc_load = 1'b1; pc_load_val = start_pc;
      mem_ack = 1'b0; ir_ready = 1'b0; z_flag = 1'b0; mem_data = 16'd0;
      @(negedge clk);
      check("rst_ctrl", {25'd0, mem_req, ir_valid, inc, add, sub, halted, fetch_err}, 32'd0);
      check("rst_ir", 32'(ir), 32'd0);
      check("rst_offset", 32'(offset), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'(start_pc));
      reset = 1'b0; pc_load = 1'b0;
      exp_pc = start_pc; pend_issue = 0; pend_ctrl = 0; exp_halt = 0; halt_age = 0;
      last_ack_cyc = -1; idle = 0; req_wait = 0; stall_left = 0;
      iv_seen = 0; pulses_seen = 0; acks_done = 0;
      words.delete(); z_q.delete();
   endtask

   task automatic run(input int n);
      int budget;
      budget = 0;
      while (!timed_out && budget < 5000) begin
         tick();
         budget++;
         if (exp_halt ? (halt_age > 8) : (acks_done >= n && !pend_issue && !pend_ctrl)) break;
      end
      if (budget >= 5000) check("run_budget", 32'(budget), 32'd0);
   endtask

   initial begin
      int req_cnt;
      reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'd0;
      mem_ack = 1'b0; ir_ready = 1'b0; z_flag = 1'b0; mem_data = 16'd0;
      repeat (2) @(negedge clk);

      // Ordinary instruction with ack and ready tied high.
      ack_pct = 100; rdy_pct = 100; lat_on = 1; max_wait = 0;
      do_reset(16'h0000);
      words = '{16'h1234, 16'h0000};
      run(2);
      check("t1_ir_valid_cycles", 32'(iv_seen), 32'd2);
      check("t1_pulses", 32'(pulses_seen), 32'd2);

      // JMPF forward.
      do_reset(16'h0100);
      words = '{16'hE010, 16'h0000};
      run(2);
      check("t2_no_issue_for_jump", 32'(iv_seen), 32'd1);

      // BZF taken, then not taken.
      do_reset(16'h0000);
      words = '{16'hC004, 16'hC004, 16'h0000};
      z_q   = '{1'b1, 1'b0};
      run(3);

      // JMPB with wrap, inc wrap, imm=0 self-loops.
      do_reset(16'h0002);
      words = '{16'hD005, 16'h0000};
      run(2);
      do_reset(16'hFFFF);
      words = '{16'h0000, 16'hE000, 16'hD000, 16'h0000};
      run(4);

      // Execute stalls for 5 cycles.
      lat_on = 0;
      do_reset(16'h0000);
      words = '{16'h1234, 16'h0000};
      stall_left = 5;
      run(2);
      check("t5_ir_valid_held", 32'(iv_seen), 32'd7);

      // Reset in the middle of a fetch.
      do_reset(16'h0000);
      ack_pct = 0;
      repeat (3) tick();
      check("t5_req_up", 32'(mem_req), 32'd1);
      do_reset(16'h0055);

      // HALT.
      ack_pct = 100;
      do_reset(16'h0000);
      words = '{16'h0000, 16'hF000};
      run(3);
      check("t6_halted", 32'(halted), 32'd1);

      // Memory never answers.
      do_reset(16'h0000);
      ack_pct = 0; max_wait = 0; req_cnt = 0;
`ifdef FETCH_TIMEOUT_EN
      repeat (40) begin tick(); if (mem_req) req_cnt++; end
      check("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
      check("to_fetch_err", 32'(fetch_err), 32'd1);
      check("to_halted", 32'(halted), 32'd1);
`else
      repeat (30) begin tick(); if (mem_req) req_cnt++; end
      check("nto_req_held", 32'(req_cnt), 32'd30);
      check("nto_fetch_err", 32'(fetch_err), 32'd0);
      check("nto_halted", 32'(halted), 32'd0);
`endif

      // Randomized segments, each ending in HALT.
      for (int seg = 0; seg < 6; seg++) begin
         do_reset(16'($urandom));
         ack_pct  = 40 + $urandom_range(60);
         rdy_pct  = 30 + $urandom_range(70);
         max_wait = 8;
         run(150);
         words.push_back(16'hF000);
         run(1000);
         check("rand_halted", 32'(halted), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
